// File: rtl/regop_pkg.sv
// rtl/regop_pkg.sv - shared opcode/state types and default widths for the register-op sequencer
//
// Contents:
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default register data and address widths
//   opcode_t                        : 3-bit command opcode
//   state_t                         : sequencer FSM states
package regop_pkg;

    localparam int DEFAULT_DATA_W = 4;
    localparam int DEFAULT_ADDR_W = 2;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_LDI = 3'b101,
        OP_MOV = 3'b110,
        OP_NOP = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_EXEC  = 2'b10,
        S_WRITE = 2'b11
    } state_t;

endpackage

// File: rtl/regop_alu.sv
// rtl/regop_alu.sv - combinational ALU for the register-op sequencer
//
// Optional feature macro: REGOP_SAT_EN (ADD saturates to all-ones, SUB clamps to 0).
//
// Ports:
//   op  : opcode
//   a   : first source operand (rs1 value)
//   b   : second source operand (rs2 value)
//   imm : immediate operand
//   y   : computed result
//   c   : carry-out for ADD, borrow for SUB, 0 for all other opcodes
module regop_alu
    import regop_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] y,
    output logic              c
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    // One extra bit: MSB of the sum is the carry-out; MSB of the
    // zero-extended difference is set exactly when a < b (the borrow).
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y = '0;
        c = 1'b0;
        case (op)
            OP_ADD: begin
                c = w_sum[DATA_W];
`ifdef REGOP_SAT_EN
                y = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
`else
                y = w_sum[DATA_W-1:0];
`endif
            end
            OP_SUB: begin
                c = w_diff[DATA_W];
`ifdef REGOP_SAT_EN
                y = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];
`else
                y = w_diff[DATA_W-1:0];
`endif
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_LDI: y = imm;
            OP_MOV: y = a;
            OP_NOP: y = '0;
        endcase
    end

endmodule

// File: rtl/regop_sequencer.sv
// rtl/regop_sequencer.sv - fixed-latency IDLE/READ/EXEC/WRITE register-op command sequencer
//
// Optional feature macro: REGOP_SAT_EN (passed through to regop_alu).
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cmd_valid / cmd_ready      : command handshake
//   cmd_op, cmd_rd, cmd_rs1,
//   cmd_rs2, cmd_imm           : command fields
//   rf_read_addr1/2            : register file read addresses (driven in READ, held otherwise)
//   rf_read_data1/2            : combinational register file read data
//   rf_we, rf_write_addr,
//   rf_write_data              : register file write port (active in WRITE only)
//   done                       : one-cycle completion pulse in WRITE
//   result, carry              : last computed value and its carry/borrow
module regop_sequencer
    import regop_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rf_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    state_t            r_state;
    state_t            w_state_nxt;
    opcode_t           r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [ADDR_W-1:0] r_raddr1;
    logic [ADDR_W-1:0] r_raddr2;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_carry;

    logic              w_cmd_ready;
    logic              w_accept;
    logic              w_rf_we;
    logic              w_done;
    logic [DATA_W-1:0] w_alu_y;
    logic              w_alu_c;

    // Next state and handshake/strobe outputs. Strobes are gated with reset
    // so that a reset landing in WRITE cannot complete the write on that edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_rf_we     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = !reset;
                if (cmd_valid) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_done      = !reset;
                w_rf_we     = !reset && (r_op != OP_NOP);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = cmd_valid && w_cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath. rs1/rs2 are latched straight into the read-address registers:
    // they become visible in READ and hold until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= OP_NOP;
            r_rd     <= '0;
            r_raddr1 <= '0;
            r_raddr2 <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= opcode_t'(cmd_op);
                r_rd     <= cmd_rd;
                r_raddr1 <= cmd_rs1;
                r_raddr2 <= cmd_rs2;
                r_imm    <= cmd_imm;
            end
            if (r_state == S_READ) begin
                r_a <= rf_read_data1;
                r_b <= rf_read_data2;
            end
            // NOP leaves the previous result and carry untouched.
            if ((r_state == S_EXEC) && (r_op != OP_NOP)) begin
                r_result <= w_alu_y;
                r_carry  <= w_alu_c;
            end
        end
    end

    regop_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op  (r_op),
        .a   (r_a),
        .b   (r_b),
        .imm (r_imm),
        .y   (w_alu_y),
        .c   (w_alu_c)
    );

    // Registered values are forced to zero for the whole reset cycle, not only
    // after the reset edge.
    assign cmd_ready     = w_cmd_ready;
    assign rf_we         = w_rf_we;
    assign done          = w_done;
    assign rf_read_addr1 = reset ? '0 : r_raddr1;
    assign rf_read_addr2 = reset ? '0 : r_raddr2;
    assign rf_write_addr = reset ? '0 : r_rd;
    assign rf_write_data = reset ? '0 : r_result;
    assign result        = reset ? '0 : r_result;
    assign carry         = reset ? 1'b0 : r_carry;

endmodule

// File: tb/tb_regop_sequencer.sv
// tb/tb_regop_sequencer.sv - directed self-checking bench for regop_sequencer
module tb_regop_sequencer;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, LDI = 3'b101, MOV = 3'b110, NOP = 3'b111;

`ifdef REGOP_SAT_EN
    localparam logic [3:0] ADD_F_1  = 4'hF;
    localparam logic [3:0] SUB_2_4  = 4'h0;
    localparam logic [3:0] ADD_B_6  = 4'hF;
`else
    localparam logic [3:0] ADD_F_1  = 4'h0;
    localparam logic [3:0] SUB_2_4  = 4'hE;
    localparam logic [3:0] ADD_B_6  = 4'h1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [3:0] cmd_imm;
    logic [1:0] rf_read_addr1, rf_read_addr2;
    logic [3:0] rf_read_data1, rf_read_data2;
    logic       rf_we;
    logic [1:0] rf_write_addr;
    logic [3:0] rf_write_data;
    logic       done;
    logic [3:0] result;
    logic       carry;

    logic       rf_clr;
    logic [3:0] rf [4];
    int         cyc = 0;
    int         we_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    regop_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_rd        (cmd_rd),
        .cmd_rs1       (cmd_rs1),
        .cmd_rs2       (cmd_rs2),
        .cmd_imm       (cmd_imm),
        .rf_read_addr1 (rf_read_addr1),
        .rf_read_addr2 (rf_read_addr2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .rf_we         (rf_we),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .done          (done),
        .result        (result),
        .carry         (carry)
    );

    // Register file attached to the DUT, plus event counters.
    assign rf_read_data1 = rf[rf_read_addr1];
    assign rf_read_data2 = rf[rf_read_addr2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_we) we_cnt <= we_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (rf_clr) begin
            for (int i = 0; i < 4; i++) rf[i] <= 4'h0;
        end else if (rf_we) begin
            rf[rf_write_addr] <= rf_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command starting from a negedge in IDLE; returns at the
    // negedge of the following IDLE cycle (4 cycles per command).
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm,
                          input logic exp_we, input logic [3:0] exp_res, input logic exp_c);
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        check({tag, ".ready_in"}, cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, ".raddr1"}, rf_read_addr1, rs1);
        check({tag, ".raddr2"}, rf_read_addr2, rs2);
        @(negedge clk);
        check({tag, ".exec_done"}, done, 0);
        @(negedge clk);
        done_cyc = cyc;
        check({tag, ".done"}, done, 1);
        check({tag, ".we"}, rf_we, exp_we);
        if (exp_we) begin
            check({tag, ".waddr"}, rf_write_addr, rd);
            check({tag, ".wdata"}, rf_write_data, exp_res);
        end
        check({tag, ".result"}, result, exp_res);
        check({tag, ".carry"}, carry, exp_c);
        @(negedge clk);
        check({tag, ".ready_out"}, cmd_ready, 1);
        check({tag, ".done_off"}, done, 0);
    endtask

    logic [1:0] bb_rd  [3];
    logic [3:0] bb_imm [3];
    int         acc_cyc [3];
    int         idx, ready_hi, iters, prev, we0, dn0;
    logic       w;

    initial begin
        reset = 1'b1; rf_clr = 1'b1; cmd_valid = 1'b0;
        cmd_op = 3'b0; cmd_rd = 2'b0; cmd_rs1 = 2'b0; cmd_rs2 = 2'b0; cmd_imm = 4'h0;
        repeat (3) @(negedge clk);
        check("rst.ready", cmd_ready, 0);
        check("rst.we", rf_we, 0);
        check("rst.done", done, 0);
        check("rst.result", result, 0);
        check("rst.carry", carry, 0);
        check("rst.raddr1", rf_read_addr1, 0);
        check("rst.wdata", rf_write_data, 0);
        reset = 1'b0; rf_clr = 1'b0;
        @(negedge clk);

        prev = 0;
        for (int i = 0; i < 4; i++) begin
            do_cmd("ldi", LDI, 2'(i), 2'd0, 2'd0, 4'(1 << i), 1'b1, 4'(1 << i), 1'b0);
            if (i > 0) check("ldi.gap", done_cyc - prev, 4);
            prev = done_cyc;
        end
        check("rf0", rf[0], 4'h1);
        check("rf1", rf[1], 4'h2);
        check("rf2", rf[2], 4'h4);
        check("rf3", rf[3], 4'h8);

        do_cmd("add1_2", ADD, 2'd3, 2'd0, 2'd1, 4'h0, 1'b1, 4'h3, 1'b0);
        check("rf3.add", rf[3], 4'h3);
        do_cmd("ldi_f", LDI, 2'd2, 2'd0, 2'd0, 4'hF, 1'b1, 4'hF, 1'b0);
        do_cmd("add_ovf", ADD, 2'd2, 2'd2, 2'd0, 4'h0, 1'b1, ADD_F_1, 1'b1);
        do_cmd("ldi_4", LDI, 2'd3, 2'd0, 2'd0, 4'h4, 1'b1, 4'h4, 1'b0);
        do_cmd("sub_2_4", SUB, 2'd0, 2'd1, 2'd3, 4'h0, 1'b1, SUB_2_4, 1'b1);
        do_cmd("xor_r2", XOR_, 2'd2, 2'd2, 2'd2, 4'h0, 1'b1, 4'h0, 1'b0);
        check("rf2.xor", rf[2], 4'h0);
        do_cmd("or", OR_, 2'd1, 2'd1, 2'd3, 4'h0, 1'b1, 4'h6, 1'b0);
        do_cmd("mov", MOV, 2'd3, 2'd1, 2'd0, 4'h0, 1'b1, 4'h6, 1'b0);
        check("rf3.mov", rf[3], 4'h6);
        do_cmd("ldi_b", LDI, 2'd2, 2'd0, 2'd0, 4'hB, 1'b1, 4'hB, 1'b0);
        do_cmd("add_b_6", ADD, 2'd0, 2'd2, 2'd1, 4'h0, 1'b1, ADD_B_6, 1'b1);
        do_cmd("nop", NOP, 2'd0, 2'd0, 2'd0, 4'h9, 1'b0, ADD_B_6, 1'b1);
        check("rf0.nop", rf[0], ADD_B_6);

        // cmd_valid held high across three back-to-back commands
        bb_rd[0] = 2'd0; bb_imm[0] = 4'h5;
        bb_rd[1] = 2'd1; bb_imm[1] = 4'h9;
        bb_rd[2] = 2'd2; bb_imm[2] = 4'h3;
        idx = 0; ready_hi = 0; iters = 0;
        cmd_op = LDI; cmd_rd = bb_rd[0]; cmd_imm = bb_imm[0]; cmd_valid = 1'b1;
        for (int k = 0; k < 40 && idx < 3; k++) begin
            iters++;
            w = cmd_ready;
            if (w) begin
                ready_hi++;
                acc_cyc[idx] = cyc;
                idx++;
            end
            @(posedge clk);
            @(negedge clk);
            if (w) begin
                if (idx < 3) begin
                    cmd_rd = bb_rd[idx]; cmd_imm = bb_imm[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        check("bb.accepts", idx, 3);
        check("bb.iters", iters, 9);
        check("bb.ready_hi", ready_hi, 3);
        check("bb.gap01", acc_cyc[1] - acc_cyc[0], 4);
        check("bb.gap12", acc_cyc[2] - acc_cyc[1], 4);
        repeat (3) @(negedge clk);
        check("bb.rf0", rf[0], 4'h5);
        check("bb.rf1", rf[1], 4'h9);
        check("bb.rf2", rf[2], 4'h3);

        // reset during EXEC of ADD rd=1
        we0 = we_cnt; dn0 = done_cnt;
        cmd_op = ADD; cmd_rd = 2'd1; cmd_rs1 = 2'd0; cmd_rs2 = 2'd2; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rexec.we", rf_we, 0);
        check("rexec.done", done, 0);
        check("rexec.ready", cmd_ready, 0);
        check("rexec.result", result, 0);
        check("rexec.raddr1", rf_read_addr1, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rexec.ready_after", cmd_ready, 1);
        repeat (3) @(negedge clk);
        check("rexec.we_cnt", we_cnt, we0);
        check("rexec.done_cnt", done_cnt, dn0);
        check("rexec.rf1", rf[1], 4'h9);
        check("rexec.carry", carry, 0);

        do_cmd("post_add", ADD, 2'd3, 2'd0, 2'd2, 4'h0, 1'b1, 4'h8, 1'b0);
        do_cmd("post_and", AND_, 2'd2, 2'd1, 2'd0, 4'h0, 1'b1, 4'h1, 1'b0);
        check("post.rf3", rf[3], 4'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
